// File: rtl/jtframe_cheat_uart.sv
// jtframe_cheat_uart
//
// Byte-wide 8N1 serial transceiver for the cheat/debug CPU. One start bit,
// eight data bits LSB first and one stop bit, no parity. Everything runs in
// the CPU clock domain; a shared oversampling tick (16 ticks per bit) paces
// both directions.
//
// Ports:
//   clk       system clock, all logic on its rising edge
//   rst       synchronous active-high reset
//   uart_rx   serial input, idles high, asynchronous to clk
//   uart_tx   serial output, registered, high when idle
//   rx_data   last received byte
//   rx_error  sticky framing/overrun flag
//   rx_rdy    sticky "new byte available" flag
//   rx_clr    one-cycle strobe clearing rx_rdy and rx_error
//   tx_busy   high while a frame is being sent
//   tx_data   byte to send, sampled on tx_wr
//   tx_wr     one-cycle write strobe, ignored while busy
//
// Parameter CLK_DIVIDER: a tick occurs every CLK_DIVIDER+1 clocks, so one bit
// lasts 16*(CLK_DIVIDER+1) clocks.

module jtframe_cheat_uart #(
  parameter logic [4:0] CLK_DIVIDER = 5'd29
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic       uart_tx,
  output logic [7:0] rx_data,
  output logic       rx_error,
  output logic       rx_rdy,
  input  logic       rx_clr,
  output logic       tx_busy,
  input  logic [7:0] tx_data,
  input  logic       tx_wr
);

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_ALIGN,
    TX_START,
    TX_DATA,
    TX_STOP
  } txState_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rxState_t;

  logic [4:0] r_tickCnt;
  logic       w_tick;

  txState_t   r_txState, w_txStateNext;
  logic [3:0] r_txTickCnt, w_txTickCntNext;
  logic [2:0] r_txBitCnt, w_txBitCntNext;
  logic [7:0] r_txShift, w_txShiftNext;
  logic       r_uartTx, w_uartTxNext;
  logic       r_txBusy, w_txBusyNext;
  logic       w_txBitEnd;

  logic [1:0] r_rxSync;
  logic       r_rxPrev;
  logic       w_rxIn;
  logic       w_rxFall;
  rxState_t   r_rxState, w_rxStateNext;
  logic [3:0] r_rxTickCnt, w_rxTickCntNext;
  logic [2:0] r_rxBitCnt, w_rxBitCntNext;
  logic [7:0] r_rxShift, w_rxShiftNext;
  logic [7:0] r_rxData, w_rxDataNext;
  logic       r_rxRdy, w_rxRdyNext;
  logic       r_rxError, w_rxErrorNext;

  // Free-running oversampling tick shared by both directions.
  assign w_tick = (r_tickCnt == CLK_DIVIDER);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tickCnt <= '0;
    end else if (w_tick) begin
      r_tickCnt <= '0;
    end else begin
      r_tickCnt <= r_tickCnt + 5'd1;
    end
  end

  // ---------------------------------------------------------------------
  // Transmitter
  // ---------------------------------------------------------------------

  // A bit period ends on the 16th tick since it began.
  assign w_txBitEnd = w_tick && (r_txTickCnt == 4'd15);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_txState   <= TX_IDLE;
      r_txTickCnt <= '0;
      r_txBitCnt  <= '0;
      r_txShift   <= '0;
      r_uartTx    <= 1'b1;
      r_txBusy    <= 1'b0;
    end else begin
      r_txState   <= w_txStateNext;
      r_txTickCnt <= w_txTickCntNext;
      r_txBitCnt  <= w_txBitCntNext;
      r_txShift   <= w_txShiftNext;
      r_uartTx    <= w_uartTxNext;
      r_txBusy    <= w_txBusyNext;
    end
  end

  // TX_ALIGN waits for the next tick so every bit, the start bit included,
  // spans exactly 16 ticks.
  always_comb begin
    w_txStateNext   = r_txState;
    w_txTickCntNext = r_txTickCnt;
    w_txBitCntNext  = r_txBitCnt;
    w_txShiftNext   = r_txShift;
    w_uartTxNext    = r_uartTx;
    w_txBusyNext    = r_txBusy;
    case (r_txState)
      TX_IDLE: begin
        w_uartTxNext = 1'b1;
        if (tx_wr) begin
          w_txShiftNext = tx_data;
          w_txBusyNext  = 1'b1;
          w_txStateNext = TX_ALIGN;
        end
      end
      TX_ALIGN: begin
        if (w_tick) begin
          w_uartTxNext    = 1'b0;
          w_txTickCntNext = '0;
          w_txStateNext   = TX_START;
        end
      end
      TX_START: begin
        if (w_tick) begin
          w_txTickCntNext = r_txTickCnt + 4'd1;
          if (w_txBitEnd) begin
            w_uartTxNext   = r_txShift[0];
            w_txShiftNext  = {1'b0, r_txShift[7:1]};
            w_txBitCntNext = '0;
            w_txStateNext  = TX_DATA;
          end
        end
      end
      TX_DATA: begin
        if (w_tick) begin
          w_txTickCntNext = r_txTickCnt + 4'd1;
          if (w_txBitEnd) begin
            if (r_txBitCnt == 3'd7) begin
              w_uartTxNext  = 1'b1;
              w_txStateNext = TX_STOP;
            end else begin
              w_uartTxNext   = r_txShift[0];
              w_txShiftNext  = {1'b0, r_txShift[7:1]};
              w_txBitCntNext = r_txBitCnt + 3'd1;
            end
          end
        end
      end
      TX_STOP: begin
        if (w_tick) begin
          w_txTickCntNext = r_txTickCnt + 4'd1;
          if (w_txBitEnd) begin
            w_txBusyNext  = 1'b0;
            w_txStateNext = TX_IDLE;
          end
        end
      end
      default: begin
        w_txStateNext = TX_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------

  // Two-stage synchronizer plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rxSync <= 2'b11;
      r_rxPrev <= 1'b1;
    end else begin
      r_rxSync <= {r_rxSync[0], uart_rx};
      r_rxPrev <= r_rxSync[1];
    end
  end

  assign w_rxIn   = r_rxSync[1];
  assign w_rxFall = r_rxPrev & ~w_rxIn;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rxState   <= RX_IDLE;
      r_rxTickCnt <= '0;
      r_rxBitCnt  <= '0;
      r_rxShift   <= '0;
      r_rxData    <= '0;
      r_rxRdy     <= 1'b0;
      r_rxError   <= 1'b0;
    end else begin
      r_rxState   <= w_rxStateNext;
      r_rxTickCnt <= w_rxTickCntNext;
      r_rxBitCnt  <= w_rxBitCntNext;
      r_rxShift   <= w_rxShiftNext;
      r_rxData    <= w_rxDataNext;
      r_rxRdy     <= w_rxRdyNext;
      r_rxError   <= w_rxErrorNext;
    end
  end

  // The start bit is re-checked on its 8th tick (mid-bit); from then on every
  // 16th tick lands mid-bit. rx_clr is applied first so a frame completing in
  // the same cycle overrides it.
  always_comb begin
    w_rxStateNext   = r_rxState;
    w_rxTickCntNext = r_rxTickCnt;
    w_rxBitCntNext  = r_rxBitCnt;
    w_rxShiftNext   = r_rxShift;
    w_rxDataNext    = r_rxData;
    w_rxRdyNext     = r_rxRdy;
    w_rxErrorNext   = r_rxError;
    if (rx_clr) begin
      w_rxRdyNext   = 1'b0;
      w_rxErrorNext = 1'b0;
    end
    case (r_rxState)
      RX_IDLE: begin
        if (w_rxFall) begin
          w_rxTickCntNext = '0;
          w_rxStateNext   = RX_START;
        end
      end
      RX_START: begin
        if (w_tick) begin
          if (r_rxTickCnt == 4'd7) begin
            if (w_rxIn) begin
              w_rxStateNext = RX_IDLE;
            end else begin
              w_rxTickCntNext = '0;
              w_rxBitCntNext  = '0;
              w_rxStateNext   = RX_DATA;
            end
          end else begin
            w_rxTickCntNext = r_rxTickCnt + 4'd1;
          end
        end
      end
      RX_DATA: begin
        if (w_tick) begin
          if (r_rxTickCnt == 4'd15) begin
            w_rxShiftNext   = {w_rxIn, r_rxShift[7:1]};
            w_rxTickCntNext = '0;
            w_rxBitCntNext  = r_rxBitCnt + 3'd1;
            if (r_rxBitCnt == 3'd7) begin
              w_rxStateNext = RX_STOP;
            end
          end else begin
            w_rxTickCntNext = r_rxTickCnt + 4'd1;
          end
        end
      end
      RX_STOP: begin
        if (w_tick) begin
          if (r_rxTickCnt == 4'd15) begin
            w_rxDataNext    = r_rxShift;
            w_rxRdyNext     = 1'b1;
            w_rxErrorNext   = r_rxError | ~w_rxIn | r_rxRdy;
            w_rxTickCntNext = '0;
            w_rxStateNext   = RX_IDLE;
          end else begin
            w_rxTickCntNext = r_rxTickCnt + 4'd1;
          end
        end
      end
      default: begin
        w_rxStateNext = RX_IDLE;
      end
    endcase
  end

  assign uart_tx  = r_uartTx;
  assign tx_busy  = r_txBusy;
  assign rx_data  = r_rxData;
  assign rx_rdy   = r_rxRdy;
  assign rx_error = r_rxError;

endmodule

// File: tb/tb_jtframe_cheat_uart.sv
// Testbench for jtframe_cheat_uart. A fast instance (CLK_DIVIDER=1, 32 clocks
// per bit) carries most of the checks; a default-divider instance receives
// frames at 100 kbaud +/-2%.
module tb_jtframe_cheat_uart;

  localparam int B    = 32;
  localparam int B29  = 480;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxDrive;
  logic       rxDrive29;
  logic       loopback;
  logic       rxLine;
  logic       rx_clr;
  logic       tx_wr;
  logic [7:0] tx_data;
  logic       uart_tx;
  logic [7:0] rx_data;
  logic       rx_error;
  logic       rx_rdy;
  logic       tx_busy;

  logic       rx_clr29;
  logic       uart_tx29;
  logic [7:0] rx_data29;
  logic       rx_error29;
  logic       rx_rdy29;
  logic       tx_busy29;

  int assertCount = 0;
  int failCount   = 0;

  // Behavioural model of the receive flags.
  logic [7:0] modelData;
  logic       modelRdy;
  logic       modelErr;

  typedef struct {
    logic       viaTx;
    logic [7:0] data;
    logic       stopBit;
    logic       clrBefore;
    logic [7:0] expData;
    logic       expRdy;
    logic       expErr;
  } vec_t;

  vec_t vecs[7];

  always #5 clk = ~clk;

  assign rxLine = loopback ? uart_tx : rxDrive;

  jtframe_cheat_uart #(.CLK_DIVIDER(5'd1)) dut (
    .clk      (clk),
    .rst      (rst),
    .uart_rx  (rxLine),
    .uart_tx  (uart_tx),
    .rx_data  (rx_data),
    .rx_error (rx_error),
    .rx_rdy   (rx_rdy),
    .rx_clr   (rx_clr),
    .tx_busy  (tx_busy),
    .tx_data  (tx_data),
    .tx_wr    (tx_wr)
  );

  jtframe_cheat_uart #(.CLK_DIVIDER(5'd29)) dut29 (
    .clk      (clk),
    .rst      (rst),
    .uart_rx  (rxDrive29),
    .uart_tx  (uart_tx29),
    .rx_data  (rx_data29),
    .rx_error (rx_error29),
    .rx_rdy   (rx_rdy29),
    .rx_clr   (rx_clr29),
    .tx_busy  (tx_busy29),
    .tx_data  (8'h00),
    .tx_wr    (1'b0)
  );

  // Level of bit k (0 = start, 1..8 = data LSB first, 9 = stop) of a frame.
  function automatic logic frameBit(input logic [7:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k >= 9) return 1'b1;
    return d[k-1];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tickClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic modelClear();
    modelRdy = 1'b0;
    modelErr = 1'b0;
  endtask

  task automatic modelFrame(input logic [7:0] d, input logic stopBit);
    modelErr  = modelErr | ~stopBit | modelRdy;
    modelRdy  = 1'b1;
    modelData = d;
  endtask

  // Drive one serial frame onto the fast or the default-divider receiver.
  task automatic applyStimulus(input logic [7:0] d, input logic stopBit, input int period, input logic wide);
    for (int k = 0; k < 10; k++) begin
      if (wide) rxDrive29 = (k == 9) ? stopBit : frameBit(d, k);
      else      rxDrive   = (k == 9) ? stopBit : frameBit(d, k);
      tickClk(period);
    end
    rxDrive   = 1'b1;
    rxDrive29 = 1'b1;
  endtask

  task automatic pulseClr();
    rx_clr = 1'b1;
    @(negedge clk);
    rx_clr = 1'b0;
    modelClear();
  endtask

  task automatic pulseTxWr(input logic [7:0] d);
    tx_data = d;
    tx_wr   = 1'b1;
    @(negedge clk);
    tx_wr   = 1'b0;
  endtask

  task automatic waitTxStart();
    int n = 0;
    while (uart_tx !== 1'b0 && n < 8) begin
      @(negedge clk);
      n++;
    end
    checkOutput("tx start bit seen", uart_tx, 0);
  endtask

  task automatic waitBusyLow(input int bound);
    int n = 0;
    while (tx_busy !== 1'b0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    checkOutput("tx busy falls", tx_busy, 0);
  endtask

  // Decode a frame from uart_tx by sampling each mid-bit, then wait for
  // tx_busy to drop.
  task automatic captureTx(output logic [7:0] d, output logic stopBit);
    waitTxStart();
    tickClk(16);
    checkOutput("tx mid start bit", uart_tx, 0);
    for (int k = 1; k <= 8; k++) begin
      tickClk(B);
      d[k-1] = uart_tx;
    end
    tickClk(B);
    stopBit = uart_tx;
    waitBusyLow(40);
  endtask

  initial begin
    logic [7:0] capData;
    logic       capStop;
    int         lows;

    vecs[0] = '{1'b1, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 8'h5A, 1'b1, 1'b1, 8'h5A, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 8'h81, 1'b0, 1'b1, 8'h81, 1'b1, 1'b1};
    vecs[4] = '{1'b0, 8'h12, 1'b1, 1'b1, 8'h12, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 8'h34, 1'b1, 1'b0, 8'h34, 1'b1, 1'b1};
    vecs[6] = '{1'b0, 8'hC3, 1'b1, 1'b1, 8'hC3, 1'b1, 1'b0};

    rst       = 1'b1;
    rxDrive   = 1'b1;
    rxDrive29 = 1'b1;
    loopback  = 1'b0;
    rx_clr    = 1'b0;
    rx_clr29  = 1'b0;
    tx_wr     = 1'b0;
    tx_data   = 8'h00;
    modelData = 8'h00;
    modelClear();

    // Reset state
    tickClk(3);
    rst = 1'b0;
    tickClk(1);
    checkOutput("reset uart_tx", uart_tx, 1);
    checkOutput("reset tx_busy", tx_busy, 0);
    checkOutput("reset rx_rdy", rx_rdy, 0);
    checkOutput("reset rx_error", rx_error, 0);
    checkOutput("reset rx_data", rx_data, 8'h00);
    checkOutput("reset rx_rdy29", rx_rdy29, 0);

    // Transmit 0xA5 with exact bit lengths; a write while busy is dropped
    $display("[TB] transmit 0xA5");
    pulseTxWr(8'hA5);
    checkOutput("tx busy after write", tx_busy, 1);
    waitTxStart();
    for (int o = 1; o <= 320; o++) begin
      @(negedge clk);
      if (o == 100) begin
        tx_data = 8'h3C;
        tx_wr   = 1'b1;
      end
      if (o == 101) tx_wr = 1'b0;
      if (o < 320 && (o % 32 == 0 || o % 32 == 31)) begin
        checkOutput($sformatf("tx A5 bit %0d offset %0d", o / 32, o), uart_tx, frameBit(8'hA5, o / 32));
        checkOutput("tx busy in frame", tx_busy, 1);
      end
    end
    checkOutput("tx busy after stop", tx_busy, 0);
    checkOutput("tx idle after stop", uart_tx, 1);
    lows = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1 || tx_busy !== 1'b0) lows++;
    end
    checkOutput("no second frame", lows, 0);

    // Back-to-back write in the cycle after busy falls
    pulseTxWr(8'h3C);
    captureTx(capData, capStop);
    checkOutput("tx 3C data", capData, 8'h3C);
    checkOutput("tx 3C stop", capStop, 1);
    pulseTxWr(8'h96);
    checkOutput("back-to-back busy", tx_busy, 1);
    captureTx(capData, capStop);
    checkOutput("tx 96 data", capData, 8'h96);
    checkOutput("tx 96 stop", capStop, 1);

    // Receive vectors: loopback, framing error, overrun
    $display("[TB] receive vectors");
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].clrBefore) begin
        pulseClr();
        checkOutput($sformatf("vec %0d clr rdy", i), rx_rdy, 0);
        checkOutput($sformatf("vec %0d clr err", i), rx_error, 0);
      end
      if (vecs[i].viaTx) begin
        loopback = 1'b1;
        pulseTxWr(vecs[i].data);
        waitBusyLow(12 * B);
        tickClk(4);
        loopback = 1'b0;
      end else begin
        applyStimulus(vecs[i].data, vecs[i].stopBit, B, 1'b0);
        tickClk(4);
      end
      modelFrame(vecs[i].data, vecs[i].stopBit);
      checkOutput($sformatf("vec %0d rdy", i), rx_rdy, vecs[i].expRdy);
      checkOutput($sformatf("vec %0d err", i), rx_error, vecs[i].expErr);
      checkOutput($sformatf("vec %0d data", i), rx_data, vecs[i].expData);
    end

    // Glitch on idle line is rejected, receiver still works afterwards
    pulseClr();
    rxDrive = 1'b0;
    tickClk(4);
    rxDrive = 1'b1;
    tickClk(3 * B);
    checkOutput("glitch rdy", rx_rdy, 0);
    checkOutput("glitch err", rx_error, 0);
    applyStimulus(8'h6E, 1'b1, B, 1'b0);
    tickClk(4);
    modelFrame(8'h6E, 1'b1);
    checkOutput("after glitch rdy", rx_rdy, 1);
    checkOutput("after glitch data", rx_data, 8'h6E);
    checkOutput("after glitch err", rx_error, 0);

    // Randomized receive and transmit against the model
    $display("[TB] randomized traffic");
    for (int it = 0; it < 16; it++) begin
      logic [7:0] d;
      logic       s;
      d = 8'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        if ($urandom_range(0, 2) != 0) pulseClr();
        s = ($urandom_range(0, 3) != 0);
        applyStimulus(d, s, B - 1 + int'($urandom_range(0, 2)), 1'b0);
        tickClk(4);
        modelFrame(d, s);
        checkOutput($sformatf("rand %0d rx rdy", it), rx_rdy, modelRdy);
        checkOutput($sformatf("rand %0d rx err", it), rx_error, modelErr);
        checkOutput($sformatf("rand %0d rx data", it), rx_data, modelData);
      end else begin
        pulseTxWr(d);
        captureTx(capData, capStop);
        checkOutput($sformatf("rand %0d tx data", it), capData, d);
        checkOutput($sformatf("rand %0d tx stop", it), capStop, 1);
      end
    end

    // Default divider at 100 kbaud +2% and -2%
    $display("[TB] default divider");
    applyStimulus(8'h55, 1'b1, B29 + 10, 1'b1);
    tickClk(10);
    checkOutput("div29 +2% rdy", rx_rdy29, 1);
    checkOutput("div29 +2% data", rx_data29, 8'h55);
    checkOutput("div29 +2% err", rx_error29, 0);
    rx_clr29 = 1'b1;
    @(negedge clk);
    rx_clr29 = 1'b0;
    checkOutput("div29 clr rdy", rx_rdy29, 0);
    applyStimulus(8'h55, 1'b1, B29 - 10, 1'b1);
    tickClk(10);
    checkOutput("div29 -2% rdy", rx_rdy29, 1);
    checkOutput("div29 -2% data", rx_data29, 8'h55);
    checkOutput("div29 -2% err", rx_error29, 0);

    // Reset in the middle of a transmission
    pulseTxWr(8'h00);
    waitTxStart();
    tickClk(50);
    checkOutput("mid-frame line low", uart_tx, 0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid-frame reset uart_tx", uart_tx, 1);
    checkOutput("mid-frame reset busy", tx_busy, 0);
    checkOutput("mid-frame reset rdy", rx_rdy, 0);
    checkOutput("mid-frame reset data", rx_data, 8'h00);
    rst = 1'b0;
    tickClk(4);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
